// File: rtl/id_pkg.sv
// Shared definitions for the ID-stage register file with scoreboard.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   REG_ZERO                : address of the hardwired-zero register
//   port_slice()            : pull one fixed-width field out of a packed port bus
//   byte_merge()            : byte-lane merge of old/new data under a lane-enable mask
//
// Both helpers work on fixed maximum-width vectors. Callers zero-extend their
// operands into them and truncate the result, so one function can serve any
// instance parameterisation up to the maximum widths.
package id_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int REG_ZERO    = 0;

    localparam int MAX_DATA_W  = 256;
    localparam int MAX_LANES   = MAX_DATA_W / 8;
    localparam int MAX_PACK_W  = 512;
    localparam int MAX_SLICE_W = 64;

    // Field idx of width w from a packed bus; bits above w are zero.
    function automatic logic [MAX_SLICE_W-1:0] port_slice(
        input logic [MAX_PACK_W-1:0] vec,
        input int                    idx,
        input int                    w
    );
        logic [MAX_PACK_W-1:0]  shifted;
        logic [MAX_SLICE_W-1:0] res;
        shifted = vec >> (idx * w);
        for (int b = 0; b < MAX_SLICE_W; b++) begin
            res[b] = (b < w) ? shifted[b] : 1'b0;
        end
        return res;
    endfunction

    // Lane b of the result comes from new_v when we[b] is set, else from old_v.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_LANES-1:0]  we
    );
        logic [MAX_DATA_W-1:0] res;
        for (int b = 0; b < MAX_LANES; b++) begin
            res[b*8 +: 8] = we[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/id_sb_counter.sv
// Pending-write counter for one scoreboarded register.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : clear the count (wins over inc/dec)
//   inc         : an issue to this register was accepted
//   dec         : writeback retired a write to this register
//   cnt         : current pending count
//   underflow   : sticky; set when dec arrives with count 0, cleared by reset only
module id_sb_counter
    import id_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             uf_d, uf_q;

    // Issue stalls on a full counter, so the clamp only guards against misuse.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        uf_d  = uf_q;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && dec) begin
            // One write enters and one leaves: count is unchanged.
            cnt_d = cnt_q;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end else if (dec) begin
            if (cnt_q == '0) begin
                uf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    assign cnt       = cnt_q;
    assign underflow = uf_q;

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage general-purpose register file with a per-register write scoreboard.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   rd_en          : per-port source valid (only affects hazard detection)
//   rd_addr        : packed source addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data        : packed combinational read data with byte-lane write bypass
//   wr_we          : writeback byte-lane enables
//   wr_addr        : writeback destination
//   wr_data        : writeback data
//   wr_retire      : writeback completes one scoreboarded write to wr_addr
//   iss_valid      : decode wants to issue an instruction writing iss_addr
//   iss_addr       : destination of the issuing instruction
//   iss_stall      : issue blocked this cycle (RAW hazard or counter full)
//   flush          : clear every pending counter
//   pending_any    : registered OR of all counters
//   err_underflow  : sticky, a retire hit a zero counter
module id_regfile_sb
    import id_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic [DATA_W/8-1:0]   wr_we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_retire,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_stall,
    input  logic                  flush,
    output logic                  pending_any,
    output logic                  err_underflow
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int NLANE = DATA_W / 8;

    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NLANE-1:0]  we
    );
        return DATA_W'(byte_merge(MAX_DATA_W'(old_v), MAX_DATA_W'(new_v), MAX_LANES'(we)));
    endfunction

    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] wr_merged;

    logic [ADDR_W-1:0] ra     [NRD];
    logic [DATA_W-1:0] rd_val [NRD];
    logic [CNT_W-1:0]  cnt_rd [NRD];
    logic [NRD-1:0]    hazard;

    logic [CNT_W-1:0]  cnt_arr [NREG];
    logic [NREG-1:0]   uf_vec;
    logic [CNT_W-1:0]  cnt_iss;
    logic              sat;
    logic              issue_ok;
    logic              any_cnt;
    logic              pending_any_d, pending_any_q;

    // Source address decode.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra[i] = ADDR_W'(port_slice(MAX_PACK_W'(rd_addr), i, ADDR_W));
        end
    end

    // Register array write path; register 0 is never written.
    always_comb begin
        wr_merged = merge(regs_q[wr_addr], wr_data, wr_we);
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr_addr != ZERO_A) begin
            regs_d[wr_addr] = wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read ports with write-through bypass: enabled lanes of a same-cycle
    // write to the same register are forwarded from wr_data.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ra[i] == ZERO_A) begin
                rd_val[i] = '0;
            end else if (wr_addr == ra[i]) begin
                rd_val[i] = merge(regs_q[ra[i]], wr_data, wr_we);
            end else begin
                rd_val[i] = regs_q[ra[i]];
            end
            rd_data[i*DATA_W +: DATA_W] = rd_val[i];
        end
    end

    // RAW hazard per port. A source whose last pending write retires this
    // cycle is not a hazard: the bypass already delivers the new value.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            cnt_rd[i] = cnt_arr[ra[i]];
            hazard[i] = rd_en[i] && (ra[i] != ZERO_A) && (cnt_rd[i] != '0) &&
                        !(wr_retire && (wr_addr == ra[i]) && (cnt_rd[i] == CNT_ONE));
        end
    end

    // A full counter only blocks issue when no retire frees a slot this cycle.
    always_comb begin
        cnt_iss   = cnt_arr[iss_addr];
        sat       = (iss_addr != ZERO_A) && (cnt_iss == CNT_MAX) &&
                    !(wr_retire && (wr_addr == iss_addr));
        iss_stall = iss_valid && ((|hazard) || sat);
        issue_ok  = iss_valid && !iss_stall && !flush;
    end

    // Register 0 has no counter: it is never pending and retires to it are ignored.
    assign cnt_arr[0] = '0;
    assign uf_vec[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        id_sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .inc       (issue_ok && (iss_addr == ADDR_W'(r))),
            .dec       (wr_retire && (wr_addr == ADDR_W'(r))),
            .cnt       (cnt_arr[r]),
            .underflow (uf_vec[r])
        );
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            any_cnt = any_cnt | (cnt_arr[r] != '0);
        end
        pending_any_d = any_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_any_q <= 1'b0;
        end else begin
            pending_any_q <= pending_any_d;
        end
    end

    assign pending_any   = pending_any_q;
    // Each per-register flag is sticky, so their OR is sticky as well.
    assign err_underflow = |uf_vec;

endmodule

// File: tb/tb_id_regfile_sb.sv
module tb_id_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  wr_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_retire;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_stall;
    logic        flush;
    logic        pending_any;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;

    id_regfile_sb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_we         (wr_we),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_retire     (wr_retire),
        .iss_valid     (iss_valid),
        .iss_addr      (iss_addr),
        .iss_stall     (iss_stall),
        .flush         (flush),
        .pending_any   (pending_any),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [3:0]  we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ret;
        logic        iv;
        logic [4:0]  ia;
        logic        fl;
        logic        c0;
        logic [31:0] e0;
        logic        c1;
        logic [31:0] e1;
        logic        es;
    } vec_t;

    typedef struct {
        string       nm;
        logic        c0;
        logic [31:0] e0;
        logic        c1;
        logic [31:0] e1;
        logic        es;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[7];

    function automatic vec_t mkv(
        input string nm, input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
        input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd, input logic ret,
        input logic iv, input logic [4:0] ia, input logic fl,
        input logic c0, input logic [31:0] e0, input logic c1, input logic [31:0] e1,
        input logic es
    );
        vec_t v;
        v.nm = nm; v.en = en; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd;
        v.ret = ret; v.iv = iv; v.ia = ia; v.fl = fl;
        v.c0 = c0; v.e0 = e0; v.c1 = c1; v.e1 = e1; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, compare on the
    // falling edge, then advance past the next rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        rd_en     = v.en;
        rd_addr   = {v.a1, v.a0};
        wr_we     = v.we;
        wr_addr   = v.wa;
        wr_data   = v.wd;
        wr_retire = v.ret;
        iss_valid = v.iv;
        iss_addr  = v.ia;
        flush     = v.fl;
        e.nm = v.nm; e.c0 = v.c0; e.e0 = v.e0; e.c1 = v.c1; e.e1 = v.e1; e.es = v.es;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", v.nm);
        end else begin
            g = sb_q.pop_front();
            if (g.c0) chk({g.nm, "_rd0"}, rd_data[31:0], g.e0);
            if (g.c1) chk({g.nm, "_rd1"}, rd_data[63:32], g.e1);
            chk({g.nm, "_stall"}, {31'd0, iss_stall}, {31'd0, g.es});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(mkv("idle", 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    endtask

    task automatic iss(input string nm, input logic [4:0] ia, input logic es);
        step(mkv(nm, 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, ia, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: read/write/bypass behaviour, one vector per cycle.
        tbl[0] = mkv("wr_r3_full", 2'b00, 5'd3, 5'd0, 4'hF, 5'd3, 32'h11223344, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h11223344, 1'b1, 32'h0, 1'b0);
        tbl[1] = mkv("wr_r3_lane01", 2'b00, 5'd3, 5'd3, 4'b0011, 5'd3, 32'hAABBCCDD, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h1122CCDD, 1'b1, 32'h1122CCDD, 1'b0);
        tbl[2] = mkv("rd_r3_stored", 2'b00, 5'd3, 5'd5, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h1122CCDD, 1'b1, 32'h0, 1'b0);
        tbl[3] = mkv("wr_r5_lane23", 2'b00, 5'd5, 5'd3, 4'b1100, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'hDEAD0000, 1'b1, 32'h1122CCDD, 1'b0);
        tbl[4] = mkv("wr_r0", 2'b00, 5'd0, 5'd0, 4'hF, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
        tbl[5] = mkv("rd_r0_r5", 2'b00, 5'd0, 5'd5, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h0, 1'b1, 32'hDEAD0000, 1'b0);
        tbl[6] = mkv("wr_r5_lane0", 2'b00, 5'd3, 5'd5, 4'b0001, 5'd5, 32'h00000077, 1'b0, 1'b0, 5'd0, 1'b0,
                     1'b1, 32'h1122CCDD, 1'b1, 32'hDEAD0077, 1'b0);

        // Reset state
        rst_n = 1'b0;
        rd_en = 2'b00; rd_addr = {5'd0, 5'd5};
        wr_we = 4'h0; wr_addr = 5'd0; wr_data = 32'h0; wr_retire = 1'b0;
        iss_valid = 1'b0; iss_addr = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd0", rd_data[31:0], 32'h0);
        chk("reset_rd1", rd_data[63:32], 32'h0);
        chk("reset_stall", {31'd0, iss_stall}, 32'd0);
        chk("reset_pending", {31'd0, pending_any}, 32'd0);
        chk("reset_err", {31'd0, err_underflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i]);
        end

        // RAW hazard on r7, resolved by bypass in the retire cycle
        iss("raw_iss7", 5'd7, 1'b0);
        step(mkv("raw_stall1", 2'b01, 5'd7, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        step(mkv("raw_stall2", 2'b01, 5'd7, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        chk("raw_pending", {31'd0, pending_any}, 32'd1);
        step(mkv("raw_retire", 2'b01, 5'd7, 5'd0, 4'hF, 5'd7, 32'h5, 1'b1, 1'b1, 5'd0, 1'b0,
                 1'b1, 32'h5, 1'b0, 32'h0, 1'b0));
        idle();
        step(mkv("raw_rd7", 2'b01, 5'd7, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0,
                 1'b1, 32'h5, 1'b0, 32'h0, 1'b0));
        chk("raw_pending_clear", {31'd0, pending_any}, 32'd0);

        // Counter saturation on r9
        iss("sat_iss1", 5'd9, 1'b0);
        iss("sat_iss2", 5'd9, 1'b0);
        iss("sat_iss3", 5'd9, 1'b0);
        iss("sat_full", 5'd9, 1'b1);
        step(mkv("sat_ret_accept", 2'b00, 5'd0, 5'd0, 4'h0, 5'd9, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        iss("sat_still3", 5'd9, 1'b1);
        step(mkv("raw_cnt3_ret", 2'b10, 5'd0, 5'd9, 4'h0, 5'd9, 32'h0, 1'b1, 1'b1, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        step(mkv("sat_ret", 2'b00, 5'd0, 5'd0, 4'h0, 5'd9, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        step(mkv("raw_cnt1_byp", 2'b10, 5'd0, 5'd9, 4'hF, 5'd9, 32'h99, 1'b1, 1'b1, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b1, 32'h99, 1'b0));
        idle();
        idle();
        chk("sat_pending_clear", {31'd0, pending_any}, 32'd0);
        chk("sat_no_err", {31'd0, err_underflow}, 32'd0);

        // Register 0 is never pending and never a hazard
        step(mkv("r0_iss", 2'b10, 5'd0, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b1, 32'h0, 1'b0));
        idle();
        idle();
        chk("r0_pending", {31'd0, pending_any}, 32'd0);

        // Flush overrides a same-cycle issue, then a stale retire underflows
        iss("fl_iss1", 5'd4, 1'b0);
        iss("fl_iss2", 5'd4, 1'b0);
        step(mkv("fl_flush", 2'b00, 5'd0, 5'd0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 1'b1,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        idle();
        chk("fl_pending", {31'd0, pending_any}, 32'd0);
        chk("fl_no_err", {31'd0, err_underflow}, 32'd0);
        step(mkv("fl_ret4", 2'b00, 5'd0, 5'd0, 4'h0, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        chk("fl_err_set", {31'd0, err_underflow}, 32'd1);
        idle();
        idle();
        chk("fl_err_sticky", {31'd0, err_underflow}, 32'd1);

        // Asynchronous reset mid-operation
        iss("rst_iss6a", 5'd6, 1'b0);
        iss("rst_iss6b", 5'd6, 1'b0);
        idle();
        chk("rst_pending_pre", {31'd0, pending_any}, 32'd1);
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("rst_rd3_pre", rd_data[31:0], 32'h1122CCDD);
        rst_n = 1'b0;
        #1;
        chk("rst_pending", {31'd0, pending_any}, 32'd0);
        chk("rst_err", {31'd0, err_underflow}, 32'd0);
        chk("rst_rd3", rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mkv("rst_ret6", 2'b00, 5'd0, 5'd0, 4'h0, 5'd6, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0,
                 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        chk("rst_err_after", {31'd0, err_underflow}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- Parametrised ID-stage register file with a built-in scoreboard; next generation of the decode-stage GPR bank.
- Provides NRD combinational read ports with byte-lane write bypass and one byte-enabled writeback port.
- Keeps a per-register pending-write counter and raises a decode stall on RAW hazards.
- Sits between decode, which issues destinations and reads sources, and writeback, which writes data and retires destinations.

Parameters:
- DATA_W, 32, register width; must be a multiple of 8.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W.
- NRD, 2, number of read ports.
- CNT_W, 2, width of each pending counter; max in-flight writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_en  in  NRD  per-port source valid.
- rd_addr  in  NRD*ADDR_W  packed source addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  packed read data.
- wr_we  in  DATA_W/8  byte-lane write enables, same style as reg_we.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- wr_retire  in  1  writeback completes one scoreboarded write to wr_addr.
- iss_valid  in  1  decode wants to issue an instruction writing iss_addr.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- iss_stall  out  1  issue blocked this cycle.
- flush  in  1  clear all pending counters (pipeline flush).
- pending_any  out  1  some counter is non-zero.
- err_underflow  out  1  sticky flag: retire seen with counter 0.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all counters = 0, err_underflow = 0. Outputs settle to iss_stall = 0, pending_any = 0, rd_data = 0.
- Register 0: reads 0, writes ignored, never pending, never causes a hazard; issue or retire to address 0 has no effect.
- Read (combinational, 0 latency): rd_data[i] = stored value of rd_addr[i]. For each byte lane b with wr_we[b] = 1 and wr_addr == rd_addr[i] != 0, lane b comes from wr_data (write-through bypass). rd_data is valid regardless of rd_en.
- Write: at posedge, each lane with wr_we[b] = 1 is updated when wr_addr != 0. wr_we = 0 with wr_retire = 1 is legal and retires without writing.
- Hazard for port i: rd_en[i] && rd_addr[i] != 0 && cnt[rd_addr[i]] != 0, and NOT (wr_retire && wr_addr == rd_addr[i] && cnt == 1). The exception is resolved by the bypass in the same cycle.
- Saturation: sat = iss_addr != 0 && cnt[iss_addr] == max && !(wr_retire && wr_addr == iss_addr).
- iss_stall = iss_valid && (any port hazard || sat). It is combinational and gated by iss_valid.
- Issue is accepted when iss_valid && !iss_stall && !flush.
- Counter update at posedge, per register r:
  - flush = 1: cnt = 0 for all r, overriding issue and retire. Register writes still occur.
  - accepted issue to r and valid retire to r together: cnt unchanged.
  - accepted issue only: cnt + 1.
  - retire only with cnt > 0: cnt - 1.
  - retire with cnt == 0: cnt stays 0 and err_underflow is set. It clears only on reset.
- pending_any: registered OR of all counters, so it reflects the post-update state one cycle later.
- Reset asserted mid-operation clears all state immediately; in-flight retires afterwards raise err_underflow. This is intended and is detected by the bench.

Decomposition:
- Shared package id_pkg holds:
  - DATA_W/ADDR_W defaults;
  - the REG_ZERO constant;
  - a function that extracts packed port slices;
  - a byte-merge function (old, new, we) used by both the write path and the bypass.
- Natural sub-module: id_sb_counter, one CNT_W saturating up/down counter with flush and underflow flag, instantiated NREG-1 times via generate. The register array and bypass muxes stay in the top module.

Test Plan:
- Reset then read r5 and r0 on both ports -> rd_data = 0 on both, iss_stall = 0, pending_any = 0.
- wr_we = 4'b0011, wr_addr = 3, wr_data = 32'hAABBCCDD, old r3 = 32'h11223344, rd_addr[0] = 3 in the same cycle -> rd_data[0] = 32'h1122CCDD immediately; stored value is the same next cycle.
- Issue to r7, then next cycle rd_en[0] = 1, rd_addr[0] = 7 with iss_valid -> iss_stall = 1 until the retire cycle. In that cycle wr_retire = 1, wr_we = 4'hF, wr_data = 32'h5 -> iss_stall = 0 and rd_data[0] = 5.
- With CNT_W = 2, issue to r9 three times, then a fourth issue -> iss_stall = 1 (sat). Same cycle with wr_retire to r9 -> accepted, cnt stays 3.
- Issue to r4 twice, flush with simultaneous iss_valid to r4 -> cnt[4] = 0, issue dropped, pending_any = 0 next cycle. A later retire to r4 -> err_underflow = 1 and stays set.
- Issue to r0 with rd_en[1] = 1, rd_addr[1] = 0 -> no stall, pending_any stays 0. Write 32'hFFFFFFFF to r0 -> r0 still reads 0.
